// File: rtl/me_io_pkg.sv
// Shared types and sizing for the ME chip-edge I/O shell.
// Optional ME_IO_PARITY_EN appends one even-parity beat to every serial frame.
package me_io_pkg;

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} in_state_e;
    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} out_state_e;

    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_LANES      = 4;
    localparam int DEF_LOAD_WORDS = 256;
    localparam int DEF_RESULT_W   = 20;
    localparam int DEF_SER_LANES  = 1;

    localparam int BEATS      = DEF_RESULT_W / DEF_SER_LANES;
    localparam int BEAT_CNT_W = $clog2(BEATS + 1);
    localparam int WCNT_W     = $clog2(DEF_LOAD_WORDS);

`ifdef ME_IO_PARITY_EN
    localparam int PARITY_BEATS = 1;
`else
    localparam int PARITY_BEATS = 0;
`endif

    // Per-instance sizing, since the module parameters may differ from the defaults.
    function automatic int calc_beats(input int result_w, input int ser_lanes);
        return result_w / ser_lanes;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/me_io_shell_if.sv
// Bundle of pad-side load signals, core-side word bus, result handshake and serial pins.
interface me_io_shell_if #(
    parameter int WORD_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int RESULT_W   = 20,
    parameter int SER_LANES  = 1
) ();
    logic                          init;
    logic [LANES*WORD_WIDTH-1:0]   pad_data;
    logic [LANES*WORD_WIDTH-1:0]   core_data;
    logic                          core_valid;
    logic                          core_first;
    logic                          core_last;
    logic [RESULT_W-1:0]           res_data;
    logic                          res_valid;
    logic                          res_ready;
    logic [SER_LANES-1:0]          ser_out;
    logic                          ser_frame;

    modport slave (
        input  init, pad_data, res_data, res_valid,
        output core_data, core_valid, core_first, core_last, res_ready, ser_out, ser_frame
    );

    modport master (
        output init, pad_data, res_data, res_valid,
        input  core_data, core_valid, core_first, core_last, res_ready, ser_out, ser_frame
    );
endinterface

// File: rtl/me_io_serializer.sv
// Result serializer: captures one result per handshake and shifts it out MSB-first.
// With ME_IO_PARITY_EN an even-parity beat on lane 0 follows the data beats.
module me_io_serializer
    import me_io_pkg::*;
#(
    parameter int RESULT_W  = DEF_RESULT_W,
    parameter int SER_LANES = DEF_SER_LANES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RESULT_W-1:0]  res_data,
    input  logic                 res_valid,
    output logic                 res_ready,
    output logic [SER_LANES-1:0] ser_out,
    output logic                 ser_frame
);
    localparam int N_BEATS   = calc_beats(RESULT_W, SER_LANES);
    localparam int TOT_BEATS = N_BEATS + PARITY_BEATS;
    localparam int CNT_W     = cnt_width(N_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOT_BEATS - 1);

    generate
        if (RESULT_W % SER_LANES != 0) begin : g_bad_lanes
            $error("RESULT_W must be a multiple of SER_LANES");
        end
    endgenerate

    out_state_e           state_q, state_d;
    logic [RESULT_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`ifdef ME_IO_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_BEAT = CNT_W'(N_BEATS);
    logic                 par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef ME_IO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef ME_IO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        res_ready = 1'b0;
        ser_frame = 1'b0;
        ser_out   = '0;
`ifdef ME_IO_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    shift_d = res_data;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef ME_IO_PARITY_EN
                    par_d   = ^res_data;
`endif
                end
            end
            S_SHIFT: begin
                ser_frame = 1'b1;
`ifdef ME_IO_PARITY_EN
                if (cnt_q == PAR_BEAT)
                    ser_out = SER_LANES'(par_q);
                else
`endif
                    ser_out = shift_q[RESULT_W-1 -: SER_LANES];
                shift_d = shift_q << SER_LANES;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: rtl/me_io_shell.sv
// Chip-edge I/O shell: frames pad words into counted block loads for the ME core
// and serialises match results. ME_IO_PARITY_EN enables the serial parity beat.
module me_io_shell
    import me_io_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int LOAD_WORDS = DEF_LOAD_WORDS,
    parameter int RESULT_W   = DEF_RESULT_W,
    parameter int SER_LANES  = DEF_SER_LANES
) (
    input  logic          clk,
    input  logic          rst,
    me_io_shell_if.slave  io
);
    localparam int PW   = LANES * WORD_WIDTH;
    localparam int WC_W = cnt_width(LOAD_WORDS);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(LOAD_WORDS - 1);

    generate
        if (LOAD_WORDS < 2) begin : g_bad_load
            $error("LOAD_WORDS must be at least 2");
        end
    endgenerate

    // Stage P: pad boundary register; the framing FSM acts on this stage.
    logic [PW-1:0]   pad_q, pad_d;
    logic            init_q, init_d;
    in_state_e       state_q, state_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic [PW-1:0]   core_data_q, core_data_d;
    logic            core_valid_q, core_valid_d;
    logic            core_first_q, core_first_d;
    logic            core_last_q, core_last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q        <= '0;
            init_q       <= 1'b0;
            state_q      <= IDLE;
            wcnt_q       <= '0;
            core_data_q  <= '0;
            core_valid_q <= 1'b0;
            core_first_q <= 1'b0;
            core_last_q  <= 1'b0;
        end else begin
            pad_q        <= pad_d;
            init_q       <= init_d;
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            core_data_q  <= core_data_d;
            core_valid_q <= core_valid_d;
            core_first_q <= core_first_d;
            core_last_q  <= core_last_d;
        end
    end

    always_comb begin
        pad_d        = io.pad_data;
        init_d       = io.init;
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        core_valid_d = 1'b0;
        core_first_d = 1'b0;
        core_last_d  = 1'b0;
        // init always wins, so a restart mid-load simply reopens the frame.
        if (init_q) begin
            state_d      = LOAD;
            wcnt_d       = WC_W'(1);
            core_valid_d = 1'b1;
            core_first_d = 1'b1;
        end else if (state_q == LOAD) begin
            core_valid_d = 1'b1;
            if (wcnt_q == LAST_WORD) begin
                core_last_d = 1'b1;
                wcnt_d      = '0;
                state_d     = IDLE;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    // Non-frame words are zeroed so the core bus stays quiet between loads.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign core_data_d[gi*WORD_WIDTH +: WORD_WIDTH] =
                core_valid_d ? pad_q[gi*WORD_WIDTH +: WORD_WIDTH] : '0;
        end
    endgenerate

    assign io.core_data  = core_data_q;
    assign io.core_valid = core_valid_q;
    assign io.core_first = core_first_q;
    assign io.core_last  = core_last_q;

    me_io_serializer #(
        .RESULT_W  (RESULT_W),
        .SER_LANES (SER_LANES)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .res_data  (io.res_data),
        .res_valid (io.res_valid),
        .res_ready (io.res_ready),
        .ser_out   (io.ser_out),
        .ser_frame (io.ser_frame)
    );
endmodule

// File: tb/tb_me_io_shell.sv
// Randomised bench for me_io_shell: a 1-lane and a 4-lane instance checked every
// cycle against a frame-position / beat-queue reference model.
module tb_me_io_shell;
    localparam int WW = 8;
    localparam int LN = 4;
    localparam int LW = 256;
    localparam int RW = 20;
`ifdef ME_IO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct packed {
        logic        v;
        logic        f;
        logic        l;
        logic [31:0] d;
    } cw_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_io_shell_if #(.WORD_WIDTH(WW), .LANES(LN), .RESULT_W(RW), .SER_LANES(1)) io1 ();
    me_io_shell_if #(.WORD_WIDTH(WW), .LANES(LN), .RESULT_W(RW), .SER_LANES(4)) io4 ();

    me_io_shell #(.WORD_WIDTH(WW), .LANES(LN), .LOAD_WORDS(LW), .RESULT_W(RW), .SER_LANES(1))
        dut1 (.clk(clk), .rst(rst), .io(io1));
    me_io_shell #(.WORD_WIDTH(WW), .LANES(LN), .LOAD_WORDS(LW), .RESULT_W(RW), .SER_LANES(4))
        dut4 (.clk(clk), .rst(rst), .io(io4));

    int         n_total;
    int         n_bad;
    bit         chk_en;
    int         pos;        // index of the word within the current frame, -1 when none
    cw_t        p1, p2;     // expected word after stage P / stage C
    logic [3:0] q1[$];      // expected serial beats still to come
    logic [3:0] q4[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_beats(input int sl, input logic [19:0] d);
        logic [3:0] b;
        for (int i = 0; i < RW / sl; i++) begin
            b = 4'((d >> (RW - (i + 1) * sl)) & ((1 << sl) - 1));
            if (sl == 1) q1.push_back(b); else q4.push_back(b);
        end
        if (PB != 0) begin
            b = {3'b000, ^d};
            if (sl == 1) q1.push_back(b); else q4.push_back(b);
        end
    endtask

    task automatic step(input logic r, input logic in_i, input logic [31:0] pd,
                        input logic v1, input logic [19:0] d1,
                        input logic v4, input logic [19:0] d4);
        cw_t nw;
        @(negedge clk);
        if (chk_en) begin
            check_val("core_valid", io1.core_valid, p2.v);
            check_val("core_first", io1.core_first, p2.f);
            check_val("core_last",  io1.core_last,  p2.l);
            if (p2.v) check_val("core_data", io1.core_data, p2.d);
            check_val("res_ready1", io1.res_ready, q1.size() == 0);
            check_val("ser_frame1", io1.ser_frame, q1.size() != 0);
            check_val("ser_out1",   io1.ser_out,   (q1.size() != 0) ? q1[0] : 4'h0);
            check_val("core_valid4", io4.core_valid, 1'b0);
            check_val("res_ready4", io4.res_ready, q4.size() == 0);
            check_val("ser_frame4", io4.ser_frame, q4.size() != 0);
            check_val("ser_out4",   io4.ser_out,   (q4.size() != 0) ? q4[0] : 4'h0);
        end
        rst          = r;
        io1.init     = in_i;
        io1.pad_data = pd;
        io1.res_valid = v1;
        io1.res_data = d1;
        io4.res_valid = v4;
        io4.res_data = d4;
        // Advance the reference to the state following the next clock edge.
        if (r) begin
            pos = -1;
            p1  = '0;
            p2  = '0;
            q1.delete();
            q4.delete();
        end else begin
            p2 = p1;
            if (in_i) pos = 0;
            else if (pos >= 0 && pos < LW - 1) pos++;
            else pos = -1;
            nw.v = (pos >= 0);
            nw.f = (pos == 0);
            nw.l = (pos == LW - 1);
            nw.d = pd;
            p1   = nw;
            if (q1.size() != 0) void'(q1.pop_front());
            else if (v1) begin
                push_beats(1, d1);
                $display("tx lanes=1 result=%05h beats=%0d", d1, q1.size());
            end
            if (q4.size() != 0) void'(q4.pop_front());
            else if (v4) begin
                push_beats(4, d4);
                $display("tx lanes=4 result=%05h beats=%0d", d4, q4.size());
            end
        end
        chk_en = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        n_total = 0;
        n_bad   = 0;
        chk_en  = 1'b0;
        pos     = -1;
        p1      = '0;
        p2      = '0;
        rst     = 1'b1;
        io1.init = 1'b0; io1.pad_data = '0; io1.res_valid = 1'b0; io1.res_data = '0;
        io4.init = 1'b0; io4.pad_data = '0; io4.res_valid = 1'b0; io4.res_data = '0;

        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 20'h0, 1'b0, 20'h0);

        // Full frame from 0x03020100 with back-to-back results held valid.
        w = 32'h0302_0100;
        for (int i = 0; i < 262; i++)
            step(1'b0, i == 0, w + 32'(i), 1'b1, 20'hA5F3C, 1'b1, 20'h12345);

        // Restart at word 100 of a frame; parity-probe result 0x00007.
        for (int i = 0; i < 360; i++)
            step(1'b0, (i == 0) || (i == 100), w + 32'(i), i < 60, 20'h00007, i < 60, 20'h00007);

        // Reset at the seventh serial beat, then a fresh result in full.
        repeat (30) step(1'b0, 1'b0, 32'h0, 1'b0, 20'h0, 1'b0, 20'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 20'hA5F3C, 1'b1, 20'h12345);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 20'h0, 1'b0, 20'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 20'h0, 1'b0, 20'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 20'h5C3A1, 1'b1, 20'h6789A);
        repeat (25) step(1'b0, 1'b0, 32'h0, 1'b0, 20'h0, 1'b0, 20'h0);

        // Random traffic on both paths, including sporadic init and reset.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0, $urandom,
                 $urandom_range(0, 3) != 0, 20'($urandom),
                 $urandom_range(0, 3) != 0, 20'($urandom));

        step(1'b0, 1'b0, 32'h0, 1'b0, 20'h0, 1'b0, 20'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
